// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: opcodes, T-states, control-word layout and idle value.
// The SAP datapath imports this package too.
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // One-hot ring; the all-zero code is the terminal HALT state.
    typedef enum logic [5:0] {
        T_HALT = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } t_state_e;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } con_t;

    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    localparam logic [11:0] CON_IDLE = 12'h3E3;

    // Anything that is not a real instruction only runs the fetch cycle.
    function automatic logic is_nop(input logic [3:0] op);
        return !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
    endfunction

endpackage

// File: rtl/sap_controller_if.sv
// Controller-facing bundle: run/opcode in, control word and sequencing status out.
interface sap_controller_if;
    logic        run;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        halted;

    modport master (output run, output opcode, input con, input t_state, input halted);
    modport slave  (input run, input opcode, output con, output t_state, output halted);
endinterface

// File: rtl/sap_ring_counter.sv
// One-hot T-state sequencer with run hold, early wrap to T1 and a terminal HALT state.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     run,
    input  logic     halt_req,
    input  logic     wrap,
    output t_state_e state
);

    t_state_e state_q;
    t_state_e state_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != T_HALT && run) begin
            if (halt_req) begin
                state_d = T_HALT;
            end else if (wrap) begin
                state_d = T1;
            end else begin
                case (state_q)
                    T1:      state_d = T2;
                    T2:      state_d = T3;
                    T3:      state_d = T4;
                    T4:      state_d = T5;
                    T5:      state_d = T6;
                    T6:      state_d = T1;
                    default: state_d = T1;
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: decodes the live opcode against the registered T-state
// into the 12-bit control word, with zero latency from state to control.
module sap_controller
    import sap_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        halted
);

    t_state_e state;
    logic     halt_req;
    logic     wrap;
    con_t     con_s;

    sap_ring_counter u_ring (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .halt_req (halt_req),
        .wrap     (wrap),
        .state    (state)
    );

    // Reset and run=0 both force the idle word; only one bus driver per state.
    always_comb begin
        con_s    = con_t'(CON_IDLE);
        halt_req = 1'b0;
        if (reset && run) begin
            case (state)
                T1: begin
                    con_s.ep   = 1'b1;
                    con_s.lm_n = 1'b0;
                end
                T2: con_s.cp = 1'b1;
                T3: begin
                    con_s.ce_n = 1'b0;
                    con_s.li_n = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            con_s.ei_n = 1'b0;
                            con_s.lm_n = 1'b0;
                        end
                        OP_OUT: begin
                            con_s.ea   = 1'b1;
                            con_s.lo_n = 1'b0;
                        end
                        OP_HLT:  halt_req = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            con_s.ce_n = 1'b0;
                            con_s.la_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            con_s.ce_n = 1'b0;
                            con_s.lb_n = 1'b0;
                            con_s.su   = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        con_s.eu   = 1'b1;
                        con_s.la_n = 1'b0;
                        con_s.su   = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    // Early return to T1 after the last state that does any work.
    always_comb begin
        wrap = 1'b0;
        if (SHORT_CYCLE) begin
            case (state)
                T3:      wrap = is_nop(opcode);
                T4:      wrap = (opcode == OP_OUT);
                T5:      wrap = (opcode == OP_LDA);
                default: wrap = 1'b0;
            endcase
        end
    end

    assign con     = con_s;
    assign t_state = state;
    assign halted  = (state == T_HALT);

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: a vector table for the full ring plus
// hand-written reset, short-cycle and halt sequences.
module tb_sap_controller;

    typedef struct {
        logic        run;
        logic [3:0]  opcode;
        logic [5:0]  exp_t;
        logic [11:0] exp_con;
    } vec_t;

    logic clock;
    logic reset;
    logic run_r;
    logic [3:0] op_r;
    int checks;
    int failures;
    vec_t vecs[$];

    sap_controller_if bus0 ();
    sap_controller_if bus1 ();

    assign bus0.run    = run_r;
    assign bus0.opcode = op_r;
    assign bus1.run    = run_r;
    assign bus1.opcode = op_r;

    sap_controller #(.SHORT_CYCLE(1'b0)) dut0 (
        .clock   (clock),
        .reset   (reset),
        .run     (bus0.run),
        .opcode  (bus0.opcode),
        .con     (bus0.con),
        .t_state (bus0.t_state),
        .halted  (bus0.halted)
    );

    sap_controller #(.SHORT_CYCLE(1'b1)) dut1 (
        .clock   (clock),
        .reset   (reset),
        .run     (bus1.run),
        .opcode  (bus1.opcode),
        .con     (bus1.con),
        .t_state (bus1.t_state),
        .halted  (bus1.halted)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] op, input logic [5:0] t, input logic [11:0] c);
        vec_t v;
        v.run = r;
        v.opcode = op;
        v.exp_t = t;
        v.exp_con = c;
        vecs.push_back(v);
    endtask

    // Drive inputs just after a falling edge, sample 1ns later, then wait for the next falling edge.
    task automatic step(input bit which, input logic r, input logic [3:0] op,
                        input logic [5:0] t, input logic [11:0] c, input logic h, input string tag);
        run_r = r;
        op_r  = op;
        #1;
        if (which == 1'b0) begin
            check({tag, "_t"}, {6'd0, bus0.t_state}, {6'd0, t});
            check({tag, "_con"}, bus0.con, c);
            check({tag, "_halted"}, {11'd0, bus0.halted}, {11'd0, h});
        end else begin
            check({tag, "_t"}, {6'd0, bus1.t_state}, {6'd0, t});
            check({tag, "_con"}, bus1.con, c);
            check({tag, "_halted"}, {11'd0, bus1.halted}, {11'd0, h});
        end
        @(negedge clock);
    endtask

    task automatic fetch(input bit which, input logic [3:0] op, input string tag);
        step(which, 1'b1, op, 6'h01, 12'h5E3, 1'b0, {tag, "_T1"});
        step(which, 1'b1, op, 6'h02, 12'hBE3, 1'b0, {tag, "_T2"});
        step(which, 1'b1, op, 6'h04, 12'h263, 1'b0, {tag, "_T3"});
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        run_r    = 1'b1;
        op_r     = 4'b0000;

        // Reset holds T1 / idle even with run=1 and clock running.
        repeat (2) @(negedge clock);
        #1;
        check("rst_t", {6'd0, bus0.t_state}, 12'h001);
        check("rst_con", bus0.con, 12'h3E3);
        check("rst_halted", {11'd0, bus0.halted}, 12'h000);
        @(negedge clock);

        // Full-ring table for SHORT_CYCLE=0.
        add(1, 4'b0000, 6'h01, 12'h5E3); add(1, 4'b0000, 6'h02, 12'hBE3);
        add(1, 4'b0000, 6'h04, 12'h263); add(1, 4'b0000, 6'h08, 12'h1A3);
        add(1, 4'b0000, 6'h10, 12'h2C3); add(1, 4'b0000, 6'h20, 12'h3E3);
        add(1, 4'b0001, 6'h01, 12'h5E3); add(1, 4'b0001, 6'h02, 12'hBE3);
        add(1, 4'b0001, 6'h04, 12'h263); add(1, 4'b0001, 6'h08, 12'h1A3);
        add(1, 4'b0001, 6'h10, 12'h2E1); add(1, 4'b0001, 6'h20, 12'h3C7);
        add(1, 4'b0010, 6'h01, 12'h5E3); add(1, 4'b0010, 6'h02, 12'hBE3);
        add(1, 4'b0010, 6'h04, 12'h263); add(1, 4'b0010, 6'h08, 12'h1A3);
        add(1, 4'b0010, 6'h10, 12'h2E9); add(1, 4'b0010, 6'h20, 12'h3CF);
        add(1, 4'b1110, 6'h01, 12'h5E3); add(1, 4'b1110, 6'h02, 12'hBE3);
        add(1, 4'b1110, 6'h04, 12'h263); add(1, 4'b1110, 6'h08, 12'h3F2);
        add(1, 4'b1110, 6'h10, 12'h3E3); add(1, 4'b1110, 6'h20, 12'h3E3);
        add(1, 4'b0101, 6'h01, 12'h5E3); add(1, 4'b0101, 6'h02, 12'hBE3);
        add(1, 4'b0101, 6'h04, 12'h263); add(1, 4'b0101, 6'h08, 12'h3E3);
        add(1, 4'b0101, 6'h10, 12'h3E3); add(1, 4'b0101, 6'h20, 12'h3E3);
        // Run gating: freeze in T3 for five cycles, then resume.
        add(1, 4'b0000, 6'h01, 12'h5E3); add(1, 4'b0000, 6'h02, 12'hBE3);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 6'h04, 12'h3E3);
        add(1, 4'b0000, 6'h04, 12'h263); add(1, 4'b0000, 6'h08, 12'h1A3);
        add(1, 4'b0000, 6'h10, 12'h2C3); add(1, 4'b0000, 6'h20, 12'h3E3);
        add(1, 4'b0000, 6'h01, 12'h5E3);

        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].run, vecs[i].opcode, vecs[i].exp_t, vecs[i].exp_con, 1'b0,
                 $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of T5.
        pulse_reset();
        fetch(1'b0, 4'b0000, "mid");
        step(1'b0, 1'b1, 4'b0000, 6'h08, 12'h1A3, 1'b0, "mid_T4");
        check("mid_pre_t", {6'd0, bus0.t_state}, 12'h010);
        reset = 1'b0;
        #1;
        check("mid_rst_t", {6'd0, bus0.t_state}, 12'h001);
        check("mid_rst_con", bus0.con, 12'h3E3);
        check("mid_rst_halted", {11'd0, bus0.halted}, 12'h000);
        @(negedge clock);
        reset = 1'b1;

        // Short cycle (dut1): OUT is 4 states, LDA 5, NOP 3.
        for (int k = 0; k < 2; k++) begin
            fetch(1'b1, 4'b1110, $sformatf("sc_out%0d", k));
            step(1'b1, 1'b1, 4'b1110, 6'h08, 12'h3F2, 1'b0, $sformatf("sc_out%0d_T4", k));
        end
        fetch(1'b1, 4'b0000, "sc_lda");
        step(1'b1, 1'b1, 4'b0000, 6'h08, 12'h1A3, 1'b0, "sc_lda_T4");
        step(1'b1, 1'b1, 4'b0000, 6'h10, 12'h2C3, 1'b0, "sc_lda_T5");
        fetch(1'b1, 4'b0101, "sc_nop");
        step(1'b1, 1'b1, 4'b0101, 6'h01, 12'h5E3, 1'b0, "sc_wrap_T1");

        // Halt: idle T4, then frozen in HALT until reset.
        pulse_reset();
        fetch(1'b0, 4'b1111, "hlt");
        step(1'b0, 1'b1, 4'b1111, 6'h08, 12'h3E3, 1'b0, "hlt_T4");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 4'b1111, 6'h00, 12'h3E3, 1'b1, $sformatf("hlt_hold%0d", i));
        end
        reset = 1'b0;
        #1;
        check("hlt_rst_t", {6'd0, bus0.t_state}, 12'h001);
        check("hlt_rst_halted", {11'd0, bus0.halted}, 12'h000);
        @(negedge clock);
        reset = 1'b1;
        step(1'b0, 1'b1, 4'b0000, 6'h01, 12'h5E3, 1'b0, "post_hlt_T1");
        step(1'b0, 1'b1, 4'b0000, 6'h02, 12'hBE3, 1'b0, "post_hlt_T2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 SHALL have parameter: SHORT_CYCLE, default 0, 1 = return to T1 right after the last non-NOP T-state of the instruction.
REQ-002 SHALL have port: clock  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: run  input  1  advance enable; 0 freezes the T-state and forces an idle control word.
REQ-005 SHALL have port: opcode  input  4  instruction-register upper nibble, valid from T4.
REQ-006 SHALL have port: con  output  12  control word {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}.
REQ-007 SHALL have port: t_state  output  6  one-hot T1..T6 (bit0 = T1); all-zero when halted.
REQ-008 SHALL have port: halted  output  1  high once HLT has been decoded.

Function
REQ-009 SHALL sequence the fixed 6-state ring T1->T2->...->T6->T1, one state per clock while run=1 and not halted.
REQ-010 SHALL decode opcodes LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111; every other code is NOP (fetch only).
REQ-011 SHALL drive the idle con value (all active-low bits 1, all active-high bits 0, i.e. 12'h3E3) in every state and cycle not listed below.
REQ-012 SHALL drive the fetch cycle for all opcodes: T1 Ep, Lm_n=0; T2 Cp; T3 CE_n=0, Li_n=0.
REQ-013 SHALL drive LDA: T4 Ei_n=0, Lm_n=0; T5 CE_n=0, La_n=0; T6 idle.
REQ-014 SHALL drive ADD: T4 Ei_n=0, Lm_n=0; T5 CE_n=0, Lb_n=0; T6 Eu, La_n=0.
REQ-015 SHALL drive SUB identically to ADD, with Su also asserted in T5 and T6.
REQ-016 SHALL drive OUT: T4 Ea, Lo_n=0; T5 and T6 idle.
REQ-017 SHALL, on HLT sampled in T4, drive idle con in that T4, enter HALT at the next edge, set halted=1 and t_state=0, and stay there until reset.
REQ-018 SHALL decode con combinationally from the registered state and the live opcode; zero latency from state to control word.
REQ-019 SHALL, with SHORT_CYCLE=1, return to T1 after the last active state: LDA after T5, OUT after T4, NOP after T3, ADD/SUB use the full ring.
REQ-020 SHALL, while run=0, hold the current T-state and output the idle con; on run returning to 1, resume from the held state with its normal con.
REQ-021 SHALL never assert Ep, Ei_n=0, Ea or Eu together in one cycle (single bus driver).

Reset
REQ-022 SHALL, while reset=0, force t_state=T1, halted=0 and con=idle, independent of clock.
REQ-023 SHALL, after reset deasserts, start the fetch cycle in T1 at the first edge with run=1; reset mid-instruction or in HALT aborts immediately to T1.

Structure
REQ-024 SHALL place the opcode enum, the T-state enum, the packed control-word struct, the CON bit indices and the idle constant in shared package sap_pkg, for reuse by the SAP datapath.
REQ-025 SHALL contain one sub-module, sap_ring_counter (one-hot T-state, run hold, short-cycle wrap, halt), with instruction decode in the top.

Verification
REQ-026 SHALL verify reset: reset=0 mid-T5 -> t_state=6'b000001, con=12'h3E3, halted=0 immediately, with no clock edge.
REQ-027 SHALL verify LDA: run=1, opcode=0000, SHORT_CYCLE=0 -> T1 Ep/Lm_n=0, T2 Cp, T3 CE_n/Li_n=0, T4 Ei_n/Lm_n=0, T5 CE_n/La_n=0, T6 idle, then T1.
REQ-028 SHALL verify SUB: opcode=0010 -> Su=1 in T5 and T6 only; T6 has Eu=1 and La_n=0; Su=0 in all other states.
REQ-029 SHALL verify short cycle: SHORT_CYCLE=1, opcode=1110 -> Ea/Lo_n=0 in T4, next cycle T1, so 4 cycles per instruction.
REQ-030 SHALL verify halt: opcode=1111 at T4 -> next edge halted=1, t_state=0, con=12'h3E3 for 20 further cycles; reset pulse -> T1.
REQ-031 SHALL verify run gating: run=0 during T3 for 5 cycles -> t_state holds T3 with con=12'h3E3; run=1 -> CE_n/Li_n=0 then T4.
